// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial display controller.
//   STATE_W  : encoding width of the controller FSM state
//   state_t  : FSM states IDLE, LOW, HIGH, LATCH, DONE
package p2s_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOW   = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/p2s_shreg.sv
// p2s_shreg: DATA_BITS-wide frame shift register with load / shift / hold.
//   clk, rst_n : clock, synchronous active-low clear
//   load       : capture din (has priority over shift)
//   shift      : advance one bit toward the serial end, 0 shifted in
//   din        : parallel word
//   sbit       : bit currently presented to the serial pin
// Holds its contents when neither load nor shift is asserted.
// Macro P2S_LSB_FIRST_EN: when defined the word leaves LSB first (shift
// right, sbit = bit 0); otherwise MSB first (shift left, sbit = MSB).
module p2s_shreg #(
   parameter int DATA_BITS = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 shift,
   input  logic [DATA_BITS-1:0] din,
   output logic                 sbit
);

   logic [DATA_BITS-1:0] sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
`ifdef P2S_LSB_FIRST_EN
         sr <= {1'b0, sr[DATA_BITS-1:1]};
`else
         sr <= {sr[DATA_BITS-2:0], 1'b0};
`endif
      end
   end

   // sbit is a straight flop output. After a full frame the register has
   // been filled with zeros, so the serial pin rests at 0 outside LOW/HIGH.
`ifdef P2S_LSB_FIRST_EN
   assign sbit = sr[0];
`else
   assign sbit = sr[DATA_BITS-1];
`endif

endmodule

// File: rtl/p2s_ctrl.sv
// p2s_ctrl: parallel-to-serial controller for chained display shift registers.
//   clk     : system clock, all logic on posedge
//   rst_n   : synchronous active-low reset (abandons any frame in progress)
//   start   : request to send din, accepted while busy=0 (IDLE or DONE)
//   din     : DATA_BITS-wide word, captured in the accept cycle
//   busy    : frame in progress
//   done    : one-cycle pulse at frame end
//   s_clk   : serial clock, CLK_DIV clk cycles per half-period
//   s_data  : serial data, changes only when s_clk falls
//   s_latch : latch strobe after the last bit, CLK_DIV cycles wide
// Macro P2S_LSB_FIRST_EN: LSB-first bit order (see p2s_shreg); timing unchanged.
//
// Handshake: start is sampled only in IDLE/DONE (busy=0); the word on din is
// captured on that edge and busy rises the next cycle. start/din are ignored
// while busy=1. Every output comes from a flop.
module p2s_ctrl
   import p2s_pkg::*;
#(
   parameter int DATA_BITS = 64,
   parameter int CLK_DIV   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] din,
   output logic                 busy,
   output logic                 done,
   output logic                 s_clk,
   output logic                 s_data,
   output logic                 s_latch
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(DATA_BITS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BITS_INIT = CNT_W'(DATA_BITS);

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] bit_cnt;
   logic             div_last;
   logic             accept;
   logic             shift;

   assign div_last = (div_cnt == DIV_LAST);
   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
   // Shift on the last HIGH cycle so the next bit appears as s_clk falls.
   assign shift    = (state == ST_HIGH) && div_last;

   p2s_shreg #(
      .DATA_BITS (DATA_BITS)
   ) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .shift (shift),
      .din   (din),
      .sbit  (s_data)
   );

   // Outputs are assigned together with the state they belong to, so they
   // switch on the same edge the state is entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         s_clk   <= 1'b0;
         s_latch <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_LOW;
                  bit_cnt <= BITS_INIT;
                  div_cnt <= '0;
                  busy    <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_LOW: begin
               if (div_last) begin
                  div_cnt <= '0;
                  s_clk   <= 1'b1;
                  state   <= ST_HIGH;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_HIGH: begin
               if (div_last) begin
                  div_cnt <= '0;
                  bit_cnt <= bit_cnt - 1'b1;
                  s_clk   <= 1'b0;
                  if (bit_cnt == CNT_W'(1)) begin
                     s_latch <= 1'b1;
                     state   <= ST_LATCH;
                  end else begin
                     state <= ST_LOW;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_LATCH: begin
               if (div_last) begin
                  div_cnt <= '0;
                  s_latch <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p2s_ctrl.sv
// tb_p2s_ctrl: directed bench for p2s_ctrl (DATA_BITS=64).
// Default build: CLK_DIV=2, MSB first. With P2S_LSB_FIRST_EN defined the
// bench switches to CLK_DIV=1 and LSB-first reconstruction.
module tb_p2s_ctrl;

   localparam int N = 64;
`ifdef P2S_LSB_FIRST_EN
   localparam int CD = 1;
`else
   localparam int CD = 2;
`endif
   // One frame: N bits of (LOW+HIGH) plus the LATCH phase.
   localparam int BUSY_EXP = 2 * CD * N + CD;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [N-1:0] din;
   logic         busy, done, s_clk, s_data, s_latch;

   p2s_ctrl #(
      .DATA_BITS (N),
      .CLK_DIV   (CD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .din     (din),
      .busy    (busy),
      .done    (done),
      .s_clk   (s_clk),
      .s_data  (s_data),
      .s_latch (s_latch)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   logic         got_q[$];
   logic [N-1:0] exp_q[$];
   int           busy_cyc, latch_cyc, done_cnt;
   logic         prev_sclk = 1'b0;
   logic         first_bit;
   int           n_cmp = 0;
   int           n_bad = 0;

   // Sample half a cycle after the active edge; a 0->1 on s_clk marks the
   // rising edge seen by the shift chain, s_data is captured there.
   always @(negedge clk) begin
      if (s_clk && !prev_sclk) got_q.push_back(s_data);
      prev_sclk = s_clk;
      if (busy)    busy_cyc++;
      if (s_latch) latch_cyc++;
      if (done)    done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      busy_cyc  = 0;
      latch_cyc = 0;
      done_cnt  = 0;
   endtask

   // Rebuild one word from the captured serial bits in wire order.
   function automatic logic [N-1:0] pop_word();
      logic [N-1:0] w;
      logic         b;
      w = '0;
      for (int i = 0; i < N; i++) begin
         b = (got_q.size() > 0) ? got_q.pop_front() : 1'b0;
`ifdef P2S_LSB_FIRST_EN
         w = {b, w[N-1:1]};
`else
         w = {w[N-2:0], b};
`endif
      end
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [N-1:0] word);
      @(posedge clk); #1;
      start = 1'b1;
      din   = word;
      @(posedge clk); #1;
      start = 1'b0;
      din   = {$urandom, $urandom};
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (done) break;
      end
      check({tag, "_done_seen"}, 64'(done), 64'd1);
   endtask

   task automatic run_frame(input string tag, input logic [N-1:0] word);
      clear_mon();
      exp_q.push_back(word);
      pulse_start(word);
      wait_done(tag);
      repeat (4) @(negedge clk);
      first_bit = (got_q.size() > 0) ? got_q[0] : 1'bx;
      check({tag, "_nbits"}, 64'(got_q.size()), 64'(N));
      check({tag, "_data"},  pop_word(), exp_q.pop_front());
      check({tag, "_busy"},  64'(busy_cyc), 64'(BUSY_EXP));
      check({tag, "_latch"}, 64'(latch_cyc), 64'(CD));
      check({tag, "_done"},  64'(done_cnt), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [N-1:0] w1;
      rst_n = 1'b0;
      start = 1'b1;
      din   = 64'hDEAD_BEEF_CAFE_F00D;

      // Reset held with start asserted: everything stays low.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_outs", {59'd0, busy, done, s_clk, s_data, s_latch}, 64'd0);
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_reset", {59'd0, busy, done, s_clk, s_data, s_latch}, 64'd0);

      // Basic frame.
      run_frame("basic", 64'hA5A5_0000_FFFF_1234);

      // Busy rejection: a second start mid-frame must be ignored.
      w1 = 64'hC3C3_5A5A_0F0F_9669;
      clear_mon();
      exp_q.push_back(w1);
      pulse_start(w1);
      repeat (50) @(posedge clk);
      #1;
      start = 1'b1;
      din   = 64'h1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("reject");
      repeat (30) @(negedge clk);
      check("reject_nbits", 64'(got_q.size()), 64'(N));
      check("reject_data",  pop_word(), exp_q.pop_front());
      check("reject_done",  64'(done_cnt), 64'd1);
      check("reject_busy",  64'(busy_cyc), 64'(BUSY_EXP));

      // Back-to-back: start held high across the DONE cycle.
      clear_mon();
      exp_q.push_back({N{1'b1}});
      exp_q.push_back({N{1'b0}});
      @(posedge clk); #1;
      start = 1'b1;
      din   = {N{1'b1}};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (busy) break;
      end
      din = '0;
      wait_done("b2b1");
      @(negedge clk);
      check("b2b_no_gap_busy", 64'(busy), 64'd1);
      check("b2b_no_gap_sclk", 64'(s_clk), 64'd0);
      start = 1'b0;
      wait_done("b2b2");
      repeat (30) @(negedge clk);
      check("b2b_done",  64'(done_cnt), 64'd2);
      check("b2b_nbits", 64'(got_q.size()), 64'(2 * N));
      check("b2b_data0", pop_word(), exp_q.pop_front());
      check("b2b_data1", pop_word(), exp_q.pop_front());
      check("b2b_busy",  64'(busy_cyc), 64'(2 * BUSY_EXP));

      // Mid-frame reset after 40 serial clocks.
      clear_mon();
      pulse_start(64'h0123_4567_89AB_CDEF);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (got_q.size() >= 40) break;
      end
      check("midrst_reached40", 64'(got_q.size() >= 40), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_outs", {59'd0, busy, done, s_clk, s_data, s_latch}, 64'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("midrst_no_done",  64'(done_cnt), 64'd0);
      check("midrst_no_latch", 64'(latch_cyc), 64'd0);
      check("midrst_idle",     {59'd0, busy, done, s_clk, s_data, s_latch}, 64'd0);
      run_frame("after_rst", 64'hFEDC_BA98_7654_3210);

`ifdef P2S_LSB_FIRST_EN
      run_frame("lsb_one", 64'h0000_0000_0000_0001);
      check("lsb_first_bit", 64'(first_bit), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/p2s_ctrl.md
Name: p2s_ctrl

Overview:
Parallel-to-serial controller for the board's chained serial-in shift registers (LED/7-segment display drivers). Accepts a DATA_BITS-wide word on a start/busy handshake. Shifts the word out on a generated serial clock, then pulses a latch strobe. Owns the internal hold-capable shift register, and sits between the display-data mux and the board I/O pins.

Parameters:
DATA_BITS, 64, word width and number of serial bits per frame (>=2)
CLK_DIV, 2, clk cycles per s_clk half-period (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
start  in  1  request to send din; accepted when busy=0
din  in  DATA_BITS  parallel word, captured in the accept cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
s_clk  out  1  serial clock to the shift chain
s_data  out  1  serial data, stable across each s_clk rising edge
s_latch  out  1  output-register latch strobe, active high

Behaviour:
- Reset (rst_n=0 at posedge): busy=0, done=0, s_clk=0, s_data=0, s_latch=0; FSM=IDLE; counters=0; shift register cleared. Applies mid-frame: the frame is abandoned, with no done and no latch.
- FSM states: IDLE, LOW, HIGH, LATCH, DONE.
- IDLE: if start=1, capture din into the shift register, load bit counter=DATA_BITS, go to LOW. busy=1 from the next cycle.
- LOW: s_clk=0. s_data=current MSB of the shift register. Stay CLK_DIV cycles, then go to HIGH.
- HIGH: s_clk=1, s_data held. Stay CLK_DIV cycles. On the last HIGH cycle, shift the register left by 1 (0 in) and decrement the bit counter. If the counter becomes 0, go to LATCH; otherwise go to LOW.
- LATCH: s_clk=0, s_data=0, s_latch=1 for CLK_DIV cycles, then go to DONE.
- DONE: one cycle. done=1, busy=0, s_latch=0. Next state is IDLE.
- start is also accepted in the DONE cycle, giving back-to-back frames. That frame's first LOW follows immediately.
- start while busy=1 is ignored; din changes while busy are ignored.
- busy is high for exactly 2*CLK_DIV*DATA_BITS + CLK_DIV cycles per frame.
- Counter widths:
  - bit counter $clog2(DATA_BITS+1)
  - divider counter max($clog2(CLK_DIV),1); wraps to 0 at each phase change.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- P2S_LSB_FIRST_EN.
- Defined: bits leave LSB first; the register shifts right (0 in) and s_data is the current LSB.
- Undefined: MSB first as above.
- Timing, counts and handshake are identical in both modes.

Decomposition:
- Package p2s_pkg: FSM state enum (IDLE, LOW, HIGH, LATCH, DONE) and a localparam for the state encoding width.
- One sub-module, p2s_shreg, holds DATA_BITS bits with controls load, shift and hold (hold when neither load nor shift).
  - Data in: din. Data out: serial bit.
  - Shift direction selected by P2S_LSB_FIRST_EN.
- FSM and counters stay in p2s_ctrl.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with start=1 -> all outputs 0, busy stays 0.
- Basic frame, DATA_BITS=64, CLK_DIV=2, din=64'hA5A5_0000_FFFF_1234, MSB first:
  - 64 s_clk rising edges; s_data sampled at each rise reproduces din, MSB first.
  - busy high 258 cycles, s_latch high 2 cycles, then done=1 for 1 cycle.
- Busy rejection: second start with din=64'h1 asserted mid-frame -> ignored; serial stream still equals the first word; exactly one done.
- Back-to-back: start held high continuously with words 64'hFFFF_FFFF_FFFF_FFFF then 64'h0 -> second frame's first LOW begins the cycle after done; no idle gap; 2 done pulses.
- Mid-frame reset: rst_n=0 after 40 s_clk rises -> next cycle all outputs 0, no s_latch/done; a new start then sends the full 64 bits correctly.
- P2S_LSB_FIRST_EN defined, CLK_DIV=1, din=64'h0000_0000_0000_0001 -> first sampled bit is 1, remaining 63 bits are 0; busy high 129 cycles.
